fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low (0 = reset), sampled on rising edge of clk.
REQ-003 SHALL have port: imem_addr  output  64  byte address of the instruction being fetched; equals PC register.
REQ-004 SHALL have port: imem_req  output  1  fetch request; transfer completes in a cycle with imem_req=1 and imem_ready=1.
REQ-005 SHALL have port: imem_rdata  input  32  instruction word; valid only when imem_ready=1.
REQ-006 SHALL have port: imem_ready  input  1  memory response strobe; may assert in the same cycle as imem_req (zero-wait).
REQ-007 SHALL have port: PCSrc_F  input  1  branch-taken redirect pulse from the branch-resolution stage.
REQ-008 SHALL have port: PCBranch_F  input  64  redirect target; valid when PCSrc_F=1.
REQ-009 SHALL have port: stall_D  input  1  decode cannot accept; decode-side registers hold.
REQ-010 SHALL have port: instr_D  output  32  registered instruction presented to decode.
REQ-011 SHALL have port: pc_D  output  64  address of instr_D.
REQ-012 SHALL have port: valid_D  output  1  instr_D/pc_D hold a live instruction.
REQ-013 SHALL have port: Op_D  output  11  instr_D[31:21] when valid_D=1, else 11'b0 (decoder default: no writes, no branch).

Function
REQ-014 SHALL implement an FSM with states FETCH, BUFFER, DRAIN plus a one-entry skid buffer (instruction, pc) and a saved redirect target register.
REQ-015 SHALL drive imem_req=1 in FETCH and DRAIN, 0 in BUFFER and while reset=0; imem_addr SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-016 FETCH, ready=1, stall_D=0: instr_D<=imem_rdata, pc_D<=PC, valid_D<=1, PC<=PC+4, remain FETCH.
REQ-017 FETCH, ready=1, stall_D=1: skid buffer<=(imem_rdata, PC), PC<=PC+4, decode regs hold, go BUFFER.
REQ-018 FETCH, ready=0: stall_D=0 -> valid_D<=0 (bubble); stall_D=1 -> decode regs hold.
REQ-019 BUFFER: stall_D=0 -> decode regs<=skid buffer, valid_D<=1, go FETCH; stall_D=1 -> hold everything.
REQ-020 PC+4 SHALL wrap modulo 2^64; no other arithmetic on PC.
REQ-021 Priority SHALL be reset > PCSrc_F > stall_D/normal flow.
REQ-022 PCSrc_F=1: valid_D<=0 regardless of stall_D; skid buffer discarded.
REQ-023 PCSrc_F=1 in FETCH with ready=1 or in BUFFER: response/buffer dropped, PC<=PCBranch_F, go FETCH.
REQ-024 PCSrc_F=1 in FETCH with ready=0: target<=PCBranch_F, PC unchanged, go DRAIN.
REQ-025 DRAIN: imem_addr held at old PC; valid_D<=0; on ready=1 response discarded, PC<=target, go FETCH.
REQ-026 PCSrc_F=1 in DRAIN: target<=PCBranch_F (latest wins); if ready=1 same cycle, PC<=PCBranch_F, go FETCH.
REQ-027 Fetch-to-decode latency SHALL be one cycle after the completing transfer (zero-wait: one instruction per cycle sustained).

Reset
REQ-028 reset=0 at a clock edge SHALL force PC=0, state FETCH, valid_D=0, instr_D=0, pc_D=0, skid buffer and target=0, from any state, mid-transfer included; any response arriving during reset SHALL be ignored.
REQ-029 First request after reset deasserts SHALL be imem_addr=0, imem_req=1 in that same cycle.

Verification
REQ-030 Zero-wait memory, stall_D=0, 4 cycles -> pc_D = 0,4,8,12 on consecutive cycles, valid_D=1 each, Op_D = instr_D[31:21].
REQ-031 ready=1 with stall_D=1 at PC=8 for 3 cycles -> state BUFFER, imem_req=0, decode regs hold pc_D=4; stall_D drops -> pc_D=8 next cycle, then fetch resumes at 12.
REQ-032 ready held 0 for 3 cycles at PC=16, PCSrc_F=1 target 0x100 on first of them -> imem_addr stays 16 until ready, response discarded, next request at 0x100, valid_D=0 throughout.
REQ-033 PCSrc_F=1 target 0x40 with stall_D=1 and zero-wait memory -> valid_D=0 next cycle, imem_addr=0x40, no instruction from old path ever reaches valid_D=1.
REQ-034 PC preset near wrap (redirect to 0xFFFF_FFFF_FFFF_FFFC) -> next imem_addr=0 after transfer.
REQ-035 reset=0 asserted while in DRAIN with ready=1 -> all outputs zero next cycle, imem_req=1 at address 0 after reset=1.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory port, absorbs decode
// stalls with a one-entry skid buffer and squashes the wrong path on redirects.
module fetch_stage (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        PCSrc_F,
    input  logic [63:0] PCBranch_F,
    input  logic        stall_D,
    output logic [31:0] instr_D,
    output logic [63:0] pc_D,
    output logic        valid_D,
    output logic [10:0] Op_D
);

    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned OPW   = 11;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        BUFFER = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    state_t           state_q,  state_d;
    logic [XLEN-1:0]  pc_q,     pc_d;
    logic [XLEN-1:0]  target_q, target_d;
    fetch_entry_t     dec_q,    dec_d;
    fetch_entry_t     skid_q,   skid_d;
    logic             valid_q,  valid_d;
    logic [XLEN-1:0]  pc_plus4;
    fetch_entry_t     resp;

    assign pc_plus4 = pc_q + PC_STEP;
    assign resp     = '{instr: imem_rdata, pc: pc_q};

    // State and datapath registers; reset overrides any response in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= FETCH;
            pc_q     <= '0;
            target_q <= '0;
            dec_q    <= '0;
            skid_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            dec_q    <= dec_d;
            skid_q   <= skid_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state and datapath updates; a redirect outranks stall and normal flow.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        dec_d    = dec_q;
        skid_d   = skid_q;
        valid_d  = valid_q;

        case (state_q)
            FETCH: begin
                if (PCSrc_F) begin
                    valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d    = PCBranch_F;
                        state_d = FETCH;
                    end else begin
                        // Request already issued at old PC; finish it before moving.
                        target_d = PCBranch_F;
                        state_d  = DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_plus4;
                    if (stall_D) begin
                        skid_d  = resp;
                        state_d = BUFFER;
                    end else begin
                        dec_d   = resp;
                        valid_d = 1'b1;
                    end
                end else if (!stall_D) begin
                    valid_d = 1'b0;
                end
            end

            BUFFER: begin
                if (PCSrc_F) begin
                    valid_d = 1'b0;
                    skid_d  = '0;
                    pc_d    = PCBranch_F;
                    state_d = FETCH;
                end else if (!stall_D) begin
                    dec_d   = skid_q;
                    valid_d = 1'b1;
                    state_d = FETCH;
                end
            end

            DRAIN: begin
                valid_d = 1'b0;
                if (PCSrc_F) begin
                    target_d = PCBranch_F;
                    if (imem_ready) begin
                        pc_d    = PCBranch_F;
                        state_d = FETCH;
                    end
                end else if (imem_ready) begin
                    pc_d    = target_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Memory port: address is the PC; no request while holding a buffered word.
    assign imem_addr = pc_q;
    assign imem_req  = reset && (state_q != BUFFER);

    assign instr_D = dec_q.instr;
    assign pc_D    = dec_q.pc;
    assign valid_D = valid_q;
    assign Op_D    = valid_q ? dec_q.instr[ILEN-1:ILEN-OPW] : OPW'(0);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a scoreboard
// of expected decode deliveries checked by a monitor.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [63:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        PCSrc_F;
    logic [63:0] PCBranch_F;
    logic        stall_D;
    logic [31:0] instr_D;
    logic [63:0] pc_D;
    logic        valid_D;
    logic [10:0] Op_D;

    int          n_checks;
    int          n_fail;
    logic [63:0] exp_q[$];

    logic        mon_stall;
    logic        mon_rst;
    logic [63:0] mon_pc;
    logic [31:0] mon_ins;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .PCSrc_F    (PCSrc_F),
        .PCBranch_F (PCBranch_F),
        .stall_D    (stall_D),
        .instr_D    (instr_D),
        .pc_D       (pc_D),
        .valid_D    (valid_D),
        .Op_D       (Op_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [63:0] h;
        h = a * 64'h0000_0000_9E37_79B9;
        return h[31:0] ^ 32'hC0DE_0001;
    endfunction

    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every decode-side acceptance of a live instruction must match the scoreboard head.
    always @(posedge clk) begin
        mon_stall = stall_D;
        mon_rst   = reset;
        #1;
        if (mon_rst && !mon_stall && valid_D) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL deliver: got pc_D=%h valid_D=1, required no delivery", pc_D);
            end else begin
                mon_pc  = exp_q.pop_front();
                mon_ins = mem_word(mon_pc);
                if (pc_D !== mon_pc) begin
                    n_fail++;
                    $display("FAIL deliver_pc: got %h, required %h", pc_D, mon_pc);
                end
                n_checks++;
                if (instr_D !== mon_ins) begin
                    n_fail++;
                    $display("FAIL deliver_instr: got %h, required %h", instr_D, mon_ins);
                end
                n_checks++;
                if (Op_D !== mon_ins[31:21]) begin
                    n_fail++;
                    $display("FAIL deliver_op: got %h, required %h", Op_D, mon_ins[31:21]);
                end
            end
        end
    end

    task automatic check_drained(input string name);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: got %0d undelivered, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        imem_ready = 1'b0;
        stall_D    = 1'b0;
        PCSrc_F    = 1'b0;
        PCBranch_F = '0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if (imem_addr !== 64'd0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_port: got addr=%h req=%b, required 0 0", imem_addr, imem_req);
        end
        n_checks++;
        if (valid_D !== 1'b0 || instr_D !== 32'd0 || pc_D !== 64'd0 || Op_D !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_decode: got v=%b i=%h pc=%h op=%h, required all 0",
                     valid_D, instr_D, pc_D, Op_D);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_first_req: got req=%b addr=%h, required 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(64'(4 * i));
            tick();
            n_checks++;
            if (valid_D !== 1'b1 || pc_D !== 64'(4 * i)) begin
                n_fail++;
                $display("FAIL stream_%0d: got v=%b pc=%h, required 1 %h", i, valid_D, pc_D, 64'(4 * i));
            end
        end
        imem_ready = 1'b0;
        tick();
        n_checks++;
        if (valid_D !== 1'b0 || imem_addr !== 64'd16) begin
            n_fail++;
            $display("FAIL stream_bubble: got v=%b addr=%h, required 0 10", valid_D, imem_addr);
        end
        check_drained("stream");
    endtask

    task automatic test_stall_buffer();
        do_reset();
        imem_ready = 1'b1;
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd4);
        tick();
        tick();
        stall_D = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (imem_req !== 1'b0 || pc_D !== 64'd4 || valid_D !== 1'b1 || imem_addr !== 64'd12) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got req=%b pc=%h v=%b addr=%h, required 0 4 1 c",
                         i, imem_req, pc_D, valid_D, imem_addr);
            end
        end
        stall_D = 1'b0;
        exp_q.push_back(64'd8);
        tick();
        n_checks++;
        if (pc_D !== 64'd8 || imem_req !== 1'b1 || imem_addr !== 64'd12) begin
            n_fail++;
            $display("FAIL stall_release: got pc=%h req=%b addr=%h, required 8 1 c", pc_D, imem_req, imem_addr);
        end
        exp_q.push_back(64'd12);
        tick();
        n_checks++;
        if (pc_D !== 64'd12 || valid_D !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_resume: got pc=%h v=%b, required c 1", pc_D, valid_D);
        end
        imem_ready = 1'b0;
        tick();
        check_drained("stall");
    endtask

    task automatic test_redirect_wait();
        do_reset();
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(64'(4 * i));
        for (int i = 0; i < 4; i++) tick();
        imem_ready = 1'b0;
        PCSrc_F    = 1'b1;
        PCBranch_F = 64'h100;
        for (int i = 0; i < 3; i++) begin
            tick();
            PCSrc_F    = 1'b0;
            PCBranch_F = 64'hBAD0;
            n_checks++;
            if (imem_addr !== 64'd16 || imem_req !== 1'b1 || valid_D !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_hold_%0d: got addr=%h req=%b v=%b, required 10 1 0",
                         i, imem_addr, imem_req, valid_D);
            end
        end
        imem_ready = 1'b1;
        tick();
        n_checks++;
        if (imem_addr !== 64'h100 || valid_D !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_exit: got addr=%h v=%b, required 100 0", imem_addr, valid_D);
        end
        exp_q.push_back(64'h100);
        tick();
        imem_ready = 1'b0;
        tick();
        check_drained("drain");
    endtask

    task automatic test_redirect_stall();
        do_reset();
        imem_ready = 1'b1;
        exp_q.push_back(64'd0);
        tick();
        stall_D    = 1'b1;
        PCSrc_F    = 1'b1;
        PCBranch_F = 64'h40;
        tick();
        PCSrc_F = 1'b0;
        n_checks++;
        if (valid_D !== 1'b0 || imem_addr !== 64'h40) begin
            n_fail++;
            $display("FAIL redir_stall: got v=%b addr=%h, required 0 40", valid_D, imem_addr);
        end
        tick();
        n_checks++;
        if (valid_D !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_stall_buf: got v=%b req=%b, required 0 0", valid_D, imem_req);
        end
        stall_D = 1'b0;
        exp_q.push_back(64'h40);
        exp_q.push_back(64'h44);
        tick();
        tick();
        imem_ready = 1'b0;
        tick();
        check_drained("redir_stall");
    endtask

    task automatic test_redirect_buffer();
        do_reset();
        imem_ready = 1'b1;
        stall_D    = 1'b1;
        tick();
        PCSrc_F    = 1'b1;
        PCBranch_F = 64'h80;
        tick();
        PCSrc_F = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h80 || valid_D !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_buf: got req=%b addr=%h v=%b, required 1 80 0", imem_req, imem_addr, valid_D);
        end
        stall_D = 1'b0;
        exp_q.push_back(64'h80);
        tick();
        imem_ready = 1'b0;
        tick();
        check_drained("redir_buf");
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ready = 1'b1;
        PCSrc_F    = 1'b1;
        PCBranch_F = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        PCSrc_F = 1'b0;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        n_checks++;
        if (imem_addr !== 64'd0) begin
            n_fail++;
            $display("FAIL wrap_addr: got %h, required 0", imem_addr);
        end
        exp_q.push_back(64'd0);
        tick();
        imem_ready = 1'b0;
        tick();
        check_drained("wrap");
    endtask

    task automatic test_reset_drain();
        do_reset();
        imem_ready = 1'b1;
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd4);
        tick();
        tick();
        imem_ready = 1'b0;
        PCSrc_F    = 1'b1;
        PCBranch_F = 64'h200;
        tick();
        PCSrc_F    = 1'b0;
        reset      = 1'b0;
        imem_ready = 1'b1;
        tick();
        n_checks++;
        if (imem_addr !== 64'd0 || imem_req !== 1'b0 || valid_D !== 1'b0 ||
            instr_D !== 32'd0 || pc_D !== 64'd0 || Op_D !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_drain: got addr=%h req=%b v=%b i=%h pc=%h op=%h, required all 0",
                     imem_addr, imem_req, valid_D, instr_D, pc_D, Op_D);
        end
        reset      = 1'b1;
        imem_ready = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_drain_req: got req=%b addr=%h, required 1 0", imem_req, imem_addr);
        end
        imem_ready = 1'b1;
        exp_q.push_back(64'd0);
        tick();
        imem_ready = 1'b0;
        tick();
        check_drained("reset_drain");
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        imem_ready = 1'b0;
        stall_D    = 1'b0;
        PCSrc_F    = 1'b0;
        PCBranch_F = '0;
        test_reset();
        test_stream();
        test_stall_buffer();
        test_redirect_wait();
        test_redirect_stall();
        test_redirect_buffer();
        test_wrap();
        test_reset_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within bound");
        $fatal(1);
    end

endmodule
